// File: rtl/counter_bcd_capture_ndigits.sv
// N-digit BCD event counter with capture register, sticky overflow and wrap/saturate mode.
// Define BCD_LEADING_ZERO_BLANK_EN to register a leading-zero blank mask alongside the captured value.
module counter_bcd_capture_ndigits #(
  parameter int DIGITS_NUM = 6,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    count_in,
  input  logic                    capture_in,
  input  logic                    clear_in,
  output logic [4*DIGITS_NUM-1:0] count_out,
  output logic [4*DIGITS_NUM-1:0] captured_out,
  output logic                    captured_ovf_out,
  output logic                    capture_valid_out,
  output logic                    overflow_out,
  output logic [DIGITS_NUM-1:0]   blank_out
);

  localparam int W = 4 * DIGITS_NUM;

  // BCD add of a single enable bit; bit W is the carry out of the top digit,
  // which is only set when every digit was 9 and the enable was high.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v, input logic en);
    logic [W:0] r;
    logic       carry;
    r     = '0;
    carry = en;
    for (int g = 0; g < DIGITS_NUM; g++) begin
      if (carry && (v[4*g +: 4] >= 4'd9)) begin
        r[4*g +: 4] = 4'd0;
      end else begin
        r[4*g +: 4] = v[4*g +: 4] + {3'd0, carry};
        carry       = 1'b0;
      end
    end
    r[W] = carry;
    return r;
  endfunction

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] captured_q, captured_d;
  logic         overflow_q, overflow_d;
  logic         cap_ovf_q, cap_ovf_d;
  logic         valid_q, valid_d;

  logic [W:0]   inc_s;
  logic         max_inc_s;
  logic [W-1:0] next_s;
  logic         ovf_next_s;

  // Live count after this edge's event, before clear/capture priority.
  always_comb begin
    inc_s      = bcd_inc(count_q, count_in);
    max_inc_s  = inc_s[W];
    if (max_inc_s && SATURATE) begin
      next_s = count_q;
    end else begin
      next_s = inc_s[W-1:0];
    end
    ovf_next_s = overflow_q | max_inc_s;
  end

  // Clear beats capture beats normal counting.
  always_comb begin
    count_d    = next_s;
    overflow_d = ovf_next_s;
    captured_d = captured_q;
    cap_ovf_d  = cap_ovf_q;
    valid_d    = 1'b0;
    if (clear_in) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (capture_in) begin
      captured_d = next_s;
      cap_ovf_d  = ovf_next_s;
      count_d    = '0;
      overflow_d = 1'b0;
      valid_d    = 1'b1;
    end else begin
      count_d    = next_s;
      overflow_d = ovf_next_s;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count_q    <= '0;
      captured_q <= '0;
      overflow_q <= 1'b0;
      cap_ovf_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      captured_q <= captured_d;
      overflow_q <= overflow_d;
      cap_ovf_q  <= cap_ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign count_out         = count_q;
  assign captured_out      = captured_q;
  assign overflow_out      = overflow_q;
  assign captured_ovf_out  = cap_ovf_q;
  assign capture_valid_out = valid_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // Bit g set when digit g and all higher digits are zero; digit 0 never blanks.
  function automatic logic [DIGITS_NUM-1:0] lead_zero_mask(input logic [W-1:0] v);
    logic [DIGITS_NUM-1:0] m;
    logic                  zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int g = DIGITS_NUM - 1; g > 0; g--) begin
      zero_above = zero_above & (v[4*g +: 4] == 4'd0);
      m[g]       = zero_above;
    end
    return m;
  endfunction

  logic [DIGITS_NUM-1:0] blank_q, blank_d;

  // Mask follows the captured value on every accepted capture.
  always_comb begin
    blank_d = blank_q;
    if (capture_in && !clear_in) begin
      blank_d = lead_zero_mask(next_s);
    end else begin
      blank_d = blank_q;
    end
  end

  // Blank mask register.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank_out = blank_q;
`else
  assign blank_out = '0;
`endif

endmodule

// File: doc/counter_bcd_capture_ndigits.md
# counter_bcd_capture_Ndigits

Parametrised N-digit BCD event counter with capture register, sticky overflow and selectable wrap/saturate mode, for the frequency-counter datapath. The live counter accumulates enabled events during a gate window; a capture strobe atomically transfers the count to a stable display register and restarts counting from zero. The display path (SSD1306 text renderer) reads only the captured value, so it never sees a count that is still changing.

## Interface
- DIGITS_NUM, 6, number of BCD digits (1..8); max count 10^DIGITS_NUM − 1
- SATURATE, 0, 0 = wrap from all-9s to 0; 1 = hold at all-9s
- clk_in  input  1  single clock; all state updates on rising edge
- reset_in  input  1  synchronous, active-high reset
- count_in  input  1  event enable; +1 on this edge when high
- capture_in  input  1  latch live count into capture register and restart live count
- clear_in  input  1  zero live count and live overflow; no capture
- count_out  output  4*DIGITS_NUM  live BCD count, digit g at [4g+3:4g]
- captured_out  output  4*DIGITS_NUM  captured BCD count
- captured_ovf_out  output  1  overflow state belonging to captured_out
- capture_valid_out  output  1  one-cycle pulse: captured_out just updated
- overflow_out  output  1  sticky live overflow
- blank_out  output  DIGITS_NUM  leading-zero mask for captured_out (see Configuration)

## Operation
- Reset (reset_in high at edge): count_out=0, captured_out=0, captured_ovf_out=0, capture_valid_out=0, overflow_out=0, blank_out=0. Reset overrides every other input.
- Increment: define next = count_out + count_in in BCD. Digit g increments when count_in is high and all lower digits are 9. A digit at 9 that increments becomes 0 and carries. The full carry chain resolves in one cycle.
- Max-count increment: an increment when count_out is all 9s sets overflow (ovf_next=1).
  - SATURATE=0: next = 0.
  - SATURATE=1: next = all 9s, unchanged.
- Otherwise ovf_next = overflow_out.
- Priority per edge, highest first:
  1. reset_in.
  2. clear_in: count_out←0, overflow_out←0. count_in and capture_in are ignored. No pulse.
  3. capture_in:
     - captured_out←next (the same-cycle event is included).
     - captured_ovf_out←ovf_next.
     - count_out←0, overflow_out←0.
     - capture_valid_out←1.
  4. Normal: count_out←next, overflow_out←ovf_next.
- capture_valid_out is high for exactly one cycle per accepted capture. Back-to-back captures give a pulse on every cycle.
- captured_out and captured_ovf_out hold between captures. clear_in does not touch them.
- Digit values never leave 0..9.

## Timing
- All outputs are registered. No combinational input-to-output path.
- Event latency: count_in high at edge k → count_out updated after edge k.
- Capture latency: capture_in at edge k → captured_out, captured_ovf_out, blank_out and capture_valid_out all valid after edge k, in the same cycle.
- The live count restarts at 0 after edge k. An event at edge k+1 gives count_out=1.
- Reset mid-operation: state is zeroed after the edge. A capture on the same edge is lost and produces no pulse.
- Critical path is the DIGITS_NUM-digit carry chain. It must close at the system clock for DIGITS_NUM=8.

## Configuration
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - blank_out is a register updated with captured_out on every capture.
  - Bit g=1 when digit g and all higher digits of the captured value are zero.
  - Bit 0 is always 0, so "0" is displayed rather than blank.
  - Example: captured 000120 → blank_out=111000.
  - Reset value is 0.
- Undefined: blank_out is tied to 0 and no blank logic or registers are generated. All other behaviour is identical.

## Test plan
Bench parameters: DIGITS_NUM=3, macro defined, both SATURATE values.
- Reset, then 125 cycles of count_in=1 → count_out=0x125, overflow_out=0, captured_out=0x000.
- From 0x998, 1 more event → 0x999. 1 more event:
  - SATURATE=0: 0x000, overflow_out=1.
  - SATURATE=1: 0x999, overflow_out=1.
  - Both: overflow stays 1 on further events.
- count_out=0x041, capture_in=1 and count_in=1 on the same edge → next cycle:
  - captured_out=0x042, capture_valid_out=1 (one cycle only), blank_out=100, count_out=0x000.
  - Then one event → count_out=0x001.
- Overflowed live count, then capture → captured_ovf_out=1 and overflow_out=0. A second capture with no overflow → captured_ovf_out=0.
- clear_in and capture_in asserted together with count_in=1, count_out=0x300 → count_out=0x000, overflow_out=0, no pulse, captured_out unchanged.
- reset_in asserted together with capture_in mid-count → all outputs 0, no pulse. Rerun with the macro undefined → blank_out is always 0 and count behaviour is identical.
